// File: rtl/fire_sequencer.sv
// Trigger/reload sequencer: synchronised, debounced buttons drive a small FSM
// that meters shots out of a magazine with cooldown and reload dead times.

module fire_sequencer_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   // A new level is accepted on the Nth consecutive sample that differs from the current one.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;

endmodule

module fire_sequencer #(
   parameter int MAG_SIZE        = 10,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int COOLDOWN_CYCLES = 10_000_000,
   parameter int RELOAD_CYCLES   = 200_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       trigger,
   input  logic       reload,
   output logic       fire,
   output logic       error,
   output logic [3:0] ammo,
   output logic       busy,
   output logic [2:0] state
);

   localparam int TIMER_MAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ? COOLDOWN_CYCLES : RELOAD_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FIRE     = 3'd1,
      COOLDOWN = 3'd2,
      EMPTY    = 3'd3,
      RELOAD   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [3:0]         ammo_q, ammo_d;
   logic               fire_q, fire_d;
   logic               error_q, error_d;
   logic               busy_q, busy_d;
   logic               trig_press, reload_press;

   fire_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_trig_db (
      .clk   (clk),
      .reset (reset),
      .raw   (trigger),
      .press (trig_press)
   );

   fire_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reload_db (
      .clk   (clk),
      .reset (reset),
      .raw   (reload),
      .press (reload_press)
   );

   // Presses outside IDLE/EMPTY simply evaporate; nothing is queued.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ammo_d  = ammo_q;
      case (state_q)
         IDLE: begin
            if (trig_press && enable && (ammo_q != 4'd0)) begin
               state_d = FIRE;
            end else if (reload_press && enable && (ammo_q < 4'(MAG_SIZE))) begin
               state_d = RELOAD;
               timer_d = TIMER_W'(RELOAD_CYCLES - 1);
            end
         end
         FIRE: begin
            if (ammo_q != 4'd0) begin
               ammo_d = ammo_q - 4'd1;
            end
            timer_d = TIMER_W'(COOLDOWN_CYCLES - 1);
            state_d = COOLDOWN;
         end
         COOLDOWN: begin
            if (timer_q == '0) begin
               state_d = (ammo_q != 4'd0) ? IDLE : EMPTY;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         EMPTY: begin
            if (reload_press && enable) begin
               state_d = RELOAD;
               timer_d = TIMER_W'(RELOAD_CYCLES - 1);
            end
         end
         RELOAD: begin
            if (timer_q == '0) begin
               ammo_d  = 4'(MAG_SIZE);
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase

      fire_d  = (state_d == FIRE);
      error_d = (state_d == EMPTY);
      busy_d  = (state_d == COOLDOWN) || (state_d == RELOAD);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         ammo_q  <= 4'(MAG_SIZE);
         fire_q  <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ammo_q  <= ammo_d;
         fire_q  <= fire_d;
         error_q <= error_d;
         busy_q  <= busy_d;
      end
   end

   assign fire  = fire_q;
   assign error = error_q;
   assign ammo  = ammo_q;
   assign busy  = busy_q;
   assign state = state_q;

endmodule
